// File: rtl/id_ex_ctrl_pkg.sv
// Shared decode/execute definitions: condition codes, NZCV bit positions,
// ALU and shifter encodings, and the E-stage control bundle with its bubble value.
package id_ex_ctrl_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
    COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;

  localparam logic [1:0] SH_MOV = 2'b00;
  localparam logic [1:0] SH_LSL = 2'b01;
  localparam logic [1:0] SH_LSR = 2'b10;
  localparam logic [1:0] SH_ASR = 2'b11;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       nowrite;
    logic [1:0] flagwrite;
    logic [3:0] alucontrol;
    logic [1:0] regcontrol;
    logic [3:0] cond;
  } ectrl_t;

  // A bubble carries AL so it always passes and can never be counted as annulled.
  localparam ectrl_t ECTRL_BUBBLE = '{
    pcsrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
    branch: 1'b0, alusrc: 1'b0, nowrite: 1'b0, flagwrite: 2'b00,
    alucontrol: ALU_ADD, regcontrol: SH_MOV, cond: COND_AL
  };

endpackage

// File: rtl/id_ex_ctrl_cond_check.sv
// Combinational ARM condition evaluation: cond field + {N,Z,C,V} -> pass.
// Zero latency; no state, no flow control.
module cond_check
  import id_ex_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condex = 1'b1;
    case (cond_e'(cond))
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL, COND_NV: condex = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// D->E control register with NZCV flags and condition gating; 1-cycle latency, StallE holds E and flags.
// ANNUL_CNT_EN adds a 16-bit wrapping count of condition-failed instructions leaving E.
module id_ex_ctrl
  import id_ex_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic       NoWriteD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] ALUControlD,
  input  logic [1:0] RegControlD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlags,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic [3:0] ALUControlE,
  output logic [1:0] RegControlE,
  output logic       CondExE,
  output logic [3:0] FlagsE
`ifdef ANNUL_CNT_EN
  ,
  output logic [15:0] annul_count
`endif
);

  ectrl_t     ctrl_d;
  ectrl_t     ctrl_q;
  logic [3:0] flags_q;

  always_comb begin
    ctrl_d            = ECTRL_BUBBLE;
    ctrl_d.pcsrc      = PCSrcD;
    ctrl_d.regwrite   = RegWriteD;
    ctrl_d.memtoreg   = MemtoRegD;
    ctrl_d.memwrite   = MemWriteD;
    ctrl_d.branch     = BranchD;
    ctrl_d.alusrc     = ALUSrcD;
    ctrl_d.nowrite    = NoWriteD;
    ctrl_d.flagwrite  = FlagWriteD;
    ctrl_d.alucontrol = ALUControlD;
    ctrl_d.regcontrol = RegControlD;
    ctrl_d.cond       = CondD;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ctrl_q <= ECTRL_BUBBLE;
    else if (FlushE)
      ctrl_q <= ECTRL_BUBBLE;
    else if (!StallE)
      ctrl_q <= ctrl_d;
  end

  cond_check u_cond_check (
    .cond   (ctrl_q.cond),
    .flags  (flags_q),
    .condex (CondExE)
  );

  // Flags follow the instruction leaving E, so a same-cycle flush does not block them.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (!StallE && CondExE) begin
      if (ctrl_q.flagwrite[1]) begin
        flags_q[FLAG_N] <= ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (ctrl_q.flagwrite[0]) begin
        flags_q[FLAG_C] <= ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  assign FlagsE       = flags_q;
  assign PCSrcE       = ctrl_q.pcsrc & CondExE;
  assign RegWriteE    = ctrl_q.regwrite & CondExE & ~ctrl_q.nowrite;
  assign MemWriteE    = ctrl_q.memwrite & CondExE;
  assign BranchTakenE = ctrl_q.branch & CondExE;
  assign MemtoRegE    = ctrl_q.memtoreg;
  assign ALUSrcE      = ctrl_q.alusrc;
  assign ALUControlE  = ctrl_q.alucontrol;
  assign RegControlE  = ctrl_q.regcontrol;

`ifdef ANNUL_CNT_EN
  // Bubbles carry AL, so a failed condition always means a real instruction.
  always_ff @(posedge clk) begin
    if (reset)
      annul_count <= 16'h0000;
    else if (!StallE && !CondExE)
      annul_count <= annul_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Self-checking bench for id_ex_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the E stage, flags and annul counter.
module tb_id_ex_ctrl;
  import id_ex_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset, StallE, FlushE;
  logic PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD;
  logic [1:0] FlagWriteD;
  logic [3:0] ALUControlD;
  logic [1:0] RegControlD;
  logic [3:0] CondD;
  logic [3:0] ALUFlags;
  logic PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE, CondExE;
  logic [3:0] ALUControlE;
  logic [1:0] RegControlE;
  logic [3:0] FlagsE;
`ifdef ANNUL_CNT_EN
  logic [15:0] annul_count;
`endif

  int checks = 0;
  int errors = 0;

  // model of the instruction sitting in E plus architectural state
  logic m_pcsrc = 0, m_regwrite = 0, m_memtoreg = 0, m_memwrite = 0;
  logic m_branch = 0, m_alusrc = 0, m_nowrite = 0, m_bubble = 1;
  logic [1:0] m_fw = 0, m_rc = 0;
  logic [3:0] m_alu = 0, m_cond = 4'he, m_flags = 0;
  logic [15:0] m_cnt = 0;

  always #5 clk = ~clk;

  id_ex_ctrl dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .NoWriteD(NoWriteD), .FlagWriteD(FlagWriteD), .ALUControlD(ALUControlD),
    .RegControlD(RegControlD), .CondD(CondD), .ALUFlags(ALUFlags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RegControlE(RegControlE), .CondExE(CondExE),
    .FlagsE(FlagsE)
`ifdef ANNUL_CNT_EN
    , .annul_count(annul_count)
`endif
  );

  // ARM encoding: cond[3:1] picks a base test, cond[0] inverts it; 111x always passes.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic set_d(input logic pcsrc, input logic regwrite, input logic memtoreg,
                       input logic memwrite, input logic branch, input logic alusrc,
                       input logic nowrite, input logic [1:0] fw, input logic [3:0] alu,
                       input logic [1:0] rc, input logic [3:0] cond);
    PCSrcD = pcsrc; RegWriteD = regwrite; MemtoRegD = memtoreg; MemWriteD = memwrite;
    BranchD = branch; ALUSrcD = alusrc; NoWriteD = nowrite; FlagWriteD = fw;
    ALUControlD = alu; RegControlD = rc; CondD = cond;
  endtask

  task automatic set_nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 2'b00, ALU_ADD, SH_MOV, 4'he);
  endtask

  task automatic model_bubble();
    m_pcsrc = 0; m_regwrite = 0; m_memtoreg = 0; m_memwrite = 0; m_branch = 0;
    m_alusrc = 0; m_nowrite = 0; m_fw = 0; m_alu = 0; m_rc = 0; m_cond = 4'he;
    m_bubble = 1;
  endtask

  // Advance model with the inputs currently driven, then clock the DUT and settle.
  task automatic tick();
    logic pass;
    logic [3:0] nf;
    pass = cond_pass(m_cond, m_flags);
    nf = m_flags;
    if (reset) begin
      model_bubble();
      m_flags = 0;
      m_cnt = 0;
    end else begin
      if (!StallE && pass) begin
        if (m_fw[1]) nf[3:2] = ALUFlags[3:2];
        if (m_fw[0]) nf[1:0] = ALUFlags[1:0];
      end
      if (!StallE && !pass && !m_bubble) m_cnt = m_cnt + 16'd1;
      m_flags = nf;
      if (FlushE) begin
        model_bubble();
      end else if (!StallE) begin
        m_pcsrc = PCSrcD; m_regwrite = RegWriteD; m_memtoreg = MemtoRegD;
        m_memwrite = MemWriteD; m_branch = BranchD; m_alusrc = ALUSrcD;
        m_nowrite = NoWriteD; m_fw = FlagWriteD; m_alu = ALUControlD;
        m_rc = RegControlD; m_cond = CondD; m_bubble = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; StallE = 1; FlushE = 1; ALUFlags = 4'hf;
    set_d(1, 1, 1, 1, 1, 1, 0, 2'b11, 4'hf, 2'b11, 4'h0);
    tick();
    tick();
    reset = 0; StallE = 0; FlushE = 0;
    set_nop();
    checks++;
    if ({PCSrcE, RegWriteE, MemWriteE, BranchTakenE} !== 4'b0000) begin
      errors++; $display("FAIL reset_gated: got %b want 0000", {PCSrcE, RegWriteE, MemWriteE, BranchTakenE});
    end
    checks++;
    if ({MemtoRegE, ALUSrcE, ALUControlE, RegControlE} !== 8'h00) begin
      errors++; $display("FAIL reset_ungated: got %h want 00", {MemtoRegE, ALUSrcE, ALUControlE, RegControlE});
    end
    checks++;
    if (FlagsE !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", FlagsE);
    end
    checks++;
    if (CondExE !== 1'b1) begin
      errors++; $display("FAIL reset_condex: got %b want 1", CondExE);
    end
`ifdef ANNUL_CNT_EN
    checks++;
    if (annul_count !== 16'h0000) begin
      errors++; $display("FAIL reset_annul: got %h want 0000", annul_count);
    end
`endif
  endtask

  task automatic test_cmp_beq();
    ALUFlags = 4'($urandom);
    set_d(0, 1, 0, 0, 0, 0, 0, 2'b11, ALU_SUB, SH_MOV, 4'he);  // SUBS
    tick();
    ALUFlags = 4'b0100;
    set_d(1, 0, 0, 0, 1, 0, 0, 2'b00, ALU_ADD, SH_MOV, 4'h0);  // BEQ
    tick();
    checks++;
    if (FlagsE !== 4'b0100) begin
      errors++; $display("FAIL beq_flags: got %b want 0100", FlagsE);
    end
    checks++;
    if ({BranchTakenE, PCSrcE, CondExE} !== 3'b111) begin
      errors++; $display("FAIL beq_taken: got %b want 111", {BranchTakenE, PCSrcE, CondExE});
    end
    checks++;
    if (RegWriteE !== 1'b0) begin
      errors++; $display("FAIL beq_regwrite: got %b want 0", RegWriteE);
    end
  endtask

  task automatic test_annul();
    logic [15:0] cnt_before;
    cnt_before = m_cnt;
    ALUFlags = 4'b1011;
    set_d(0, 1, 0, 0, 0, 0, 0, 2'b11, ALU_ADD, SH_MOV, 4'h1);  // ADDSNE with Z=1
    tick();
    checks++;
    if ({RegWriteE, CondExE} !== 2'b00) begin
      errors++; $display("FAIL annul_gate: got %b want 00", {RegWriteE, CondExE});
    end
    set_nop();
    tick();
    checks++;
    if (FlagsE !== 4'b0100) begin
      errors++; $display("FAIL annul_flags: got %b want 0100", FlagsE);
    end
`ifdef ANNUL_CNT_EN
    checks++;
    if (annul_count !== cnt_before + 16'd1) begin
      errors++; $display("FAIL annul_count: got %h want %h", annul_count, cnt_before + 16'd1);
    end
`else
    if (m_cnt != cnt_before + 16'd1) $display("note: model count did not advance");
`endif
  endtask

  task automatic test_stall();
    set_d(0, 1, 0, 0, 0, 1, 1, 2'b11, ALU_SUB, SH_MOV, 4'he);  // CMP
    ALUFlags = 4'b0000;
    tick();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      ALUFlags = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      set_d(1'($urandom), 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0,
            2'($urandom), ALU_EOR, SH_ASR, 4'($urandom));
      tick();
      checks++;
      if ({ALUSrcE, ALUControlE, RegControlE, RegWriteE} !== {1'b1, ALU_SUB, SH_MOV, 1'b0}) begin
        errors++; $display("FAIL stall_hold_%0d: got %h want %h", i,
                           {ALUSrcE, ALUControlE, RegControlE, RegWriteE}, {1'b1, ALU_SUB, SH_MOV, 1'b0});
      end
      checks++;
      if (FlagsE !== 4'b0100) begin
        errors++; $display("FAIL stall_flags_%0d: got %b want 0100", i, FlagsE);
      end
    end
    StallE = 0;
    ALUFlags = 4'b0110;
    set_nop();
    tick();
    checks++;
    if (FlagsE !== 4'b0110) begin
      errors++; $display("FAIL stall_release_flags: got %b want 0110", FlagsE);
    end
    ALUFlags = 4'b1001;
    tick();
    checks++;
    if (FlagsE !== 4'b0110) begin
      errors++; $display("FAIL stall_once_flags: got %b want 0110", FlagsE);
    end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    set_d(0, 0, 0, 0, 0, 0, 0, 2'b01, ALU_ADD, SH_MOV, 4'he);  // sets C,V only
    tick();
    ALUFlags = 4'b1111;
    set_d(0, 1, 0, 0, 0, 0, 0, 2'b10, ALU_AND, SH_LSL, 4'he);  // ANDS
    tick();
    checks++;
    if (FlagsE !== 4'b0111) begin
      errors++; $display("FAIL flush_setup_flags: got %b want 0111", FlagsE);
    end
    cnt_before = m_cnt;
    ALUFlags = 4'b1000;
    FlushE = 1;
    set_d(0, 0, 0, 1, 0, 0, 0, 2'b00, ALU_ORR, SH_LSR, 4'he);
    tick();
    FlushE = 0;
    set_nop();
    checks++;
    if (MemWriteE !== 1'b0) begin
      errors++; $display("FAIL flush_memwrite: got %b want 0", MemWriteE);
    end
    checks++;
    if (FlagsE !== 4'b1011) begin
      errors++; $display("FAIL flush_flags: got %b want 1011", FlagsE);
    end
    checks++;
    if ({CondExE, ALUControlE, RegControlE} !== 7'b1000000) begin
      errors++; $display("FAIL flush_bubble: got %b want 1000000", {CondExE, ALUControlE, RegControlE});
    end
`ifdef ANNUL_CNT_EN
    checks++;
    if (annul_count !== cnt_before) begin
      errors++; $display("FAIL flush_annul: got %h want %h", annul_count, cnt_before);
    end
`else
    if (m_cnt != cnt_before) $display("note: model count moved on flush");
`endif
  endtask

  task automatic test_random();
    logic pass;
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      StallE = ($urandom_range(0, 4) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      ALUFlags = 4'($urandom);
      set_d(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom));
      tick();
      pass = cond_pass(m_cond, m_flags);
      checks++;
      if (CondExE !== pass) begin
        errors++; $display("FAIL rand_condex_%0d: got %b want %b", i, CondExE, pass);
      end
      checks++;
      if ({PCSrcE, RegWriteE, MemWriteE, BranchTakenE} !==
          {m_pcsrc & pass, m_regwrite & pass & ~m_nowrite, m_memwrite & pass, m_branch & pass}) begin
        errors++; $display("FAIL rand_gated_%0d: got %b want %b", i,
                           {PCSrcE, RegWriteE, MemWriteE, BranchTakenE},
                           {m_pcsrc & pass, m_regwrite & pass & ~m_nowrite, m_memwrite & pass, m_branch & pass});
      end
      checks++;
      if ({MemtoRegE, ALUSrcE, ALUControlE, RegControlE} !== {m_memtoreg, m_alusrc, m_alu, m_rc}) begin
        errors++; $display("FAIL rand_ungated_%0d: got %h want %h", i,
                           {MemtoRegE, ALUSrcE, ALUControlE, RegControlE}, {m_memtoreg, m_alusrc, m_alu, m_rc});
      end
      checks++;
      if (FlagsE !== m_flags) begin
        errors++; $display("FAIL rand_flags_%0d: got %b want %b", i, FlagsE, m_flags);
      end
`ifdef ANNUL_CNT_EN
      checks++;
      if (annul_count !== m_cnt) begin
        errors++; $display("FAIL rand_annul_%0d: got %h want %h", i, annul_count, m_cnt);
      end
`endif
    end
    reset = 0; StallE = 0; FlushE = 0;
  endtask

`ifdef ANNUL_CNT_EN
  task automatic test_wrap();
    reset = 1; StallE = 0; FlushE = 0;
    set_nop();
    tick();
    reset = 0;
    ALUFlags = 4'b0000;
    set_d(0, 1, 0, 0, 0, 0, 0, 2'b00, ALU_ADD, SH_MOV, 4'h0);  // EQ fails with Z=0
    for (int i = 0; i < 65536; i++) tick();
    checks++;
    if (annul_count !== 16'hffff || m_cnt !== 16'hffff) begin
      errors++; $display("FAIL wrap_full: got %h want ffff (model %h)", annul_count, m_cnt);
    end
    tick();
    checks++;
    if (annul_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: got %h want 0000", annul_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cmp_beq();
    test_annul();
    test_stall();
    test_flush();
    test_random();
`ifdef ANNUL_CNT_EN
    test_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
